// File: rtl/dmac_write_resp_tracker.sv
// -----------------------------------------------------------------------------
// dmac_write_resp_tracker
// Tracks in-flight AXI write bursts of a multi-channel DMA controller in issue
// order, matches each B response to its burst, accumulates per-channel error
// status and emits a one-cycle completion pulse when the final burst of a
// channel's transfer is acknowledged.
// Optional watchdog: define DMAC_WR_RESP_TIMEOUT_EN to enable the B-response
// timeout (sticky timeout_err); otherwise timeout_err is tied low.
// -----------------------------------------------------------------------------
module dmac_write_resp_tracker #(
    parameter int CHANNEL_COUNT     = 8,
    parameter int OUTSTANDING_DEPTH = 8,
    parameter int TIMEOUT_CYCLES    = 1024,
    localparam int CH_WD  = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
    localparam int CNT_WD = $clog2(OUTSTANDING_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [CH_WD-1:0]  issue_ch,
    input  logic              issue_last,
    input  logic              m_axi_bvalid,
    input  logic [1:0]        m_axi_bresp,
    output logic              m_axi_bready,
    output logic              done_valid,
    output logic [CH_WD-1:0]  done_ch,
    output logic              done_err,
    output logic [CNT_WD-1:0] outstanding_cnt,
    output logic              timeout_err
);

    localparam int                PTR_WD  = CNT_WD - 1;
    localparam logic [PTR_WD-1:0] PTR_ONE = PTR_WD'(1);
    localparam logic [CNT_WD-1:0] CNT_ONE = CNT_WD'(1);
    localparam logic [CNT_WD-1:0] DEPTH_C = CNT_WD'(OUTSTANDING_DEPTH);

    // In-order record of issued bursts; depth is a power of two so the
    // pointers wrap naturally.
    logic [CH_WD-1:0]             fifo_ch_r [OUTSTANDING_DEPTH];
    logic [OUTSTANDING_DEPTH-1:0] fifo_last_r;
    logic [PTR_WD-1:0]            wr_ptr_r;
    logic [PTR_WD-1:0]            rd_ptr_r;
    logic [CNT_WD-1:0]            cnt_r;

    logic [CHANNEL_COUNT-1:0]     err_acc_r;
    logic                         done_valid_r;
    logic [CH_WD-1:0]             done_ch_r;
    logic                         done_err_r;

    logic                         push_s;
    logic                         pop_s;
    logic                         resp_err_s;
    logic [CH_WD-1:0]             head_ch_s;
    logic                         head_last_s;
    logic                         acc_bit_s;
    logic                         unused_s;

    // Handshake qualifiers; both are held off while reset is asserted so no
    // transaction can be recorded or consumed during reset.
    assign issue_ready  = rst & (cnt_r < DEPTH_C);
    assign m_axi_bready = rst & (cnt_r != {CNT_WD{1'b0}});
    assign push_s       = issue_valid & issue_ready;
    assign pop_s        = m_axi_bvalid & m_axi_bready;

    // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
    assign resp_err_s   = m_axi_bresp[1];
    assign head_ch_s    = fifo_ch_r[rd_ptr_r];
    assign head_last_s  = fifo_last_r[rd_ptr_r];
    assign acc_bit_s    = err_acc_r[head_ch_s];

    assign unused_s     = ^{m_axi_bresp[0], (TIMEOUT_CYCLES > 0)};

    // Entry storage: written on an accepted issue, no reset needed because the
    // occupancy count alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_ch_r[wr_ptr_r]   <= issue_ch;
            fifo_last_r[wr_ptr_r] <= issue_last;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop cancel out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_WD{1'b0}};
            rd_ptr_r <= {PTR_WD{1'b0}};
            cnt_r    <= {CNT_WD{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_ONE;
                2'b01:   cnt_r <= cnt_r - CNT_ONE;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Per-channel error accumulation and registered completion reporting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_acc_r    <= {CHANNEL_COUNT{1'b0}};
            done_valid_r <= 1'b0;
            done_ch_r    <= {CH_WD{1'b0}};
            done_err_r   <= 1'b0;
        end else begin
            done_valid_r <= 1'b0;
            if (pop_s) begin
                if (head_last_s) begin
                    done_valid_r           <= 1'b1;
                    done_ch_r              <= head_ch_s;
                    done_err_r             <= acc_bit_s | resp_err_s;
                    err_acc_r[head_ch_s]   <= 1'b0;
                end else begin
                    err_acc_r[head_ch_s]   <= acc_bit_s | resp_err_s;
                end
            end
        end
    end

`ifdef DMAC_WR_RESP_TIMEOUT_EN
    localparam int               WD_WD    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_WD-1:0] WD_LIMIT = WD_WD'(TIMEOUT_CYCLES);
    localparam logic [WD_WD-1:0] WD_ONE   = WD_WD'(1);

    logic [WD_WD-1:0] wd_cnt_r;
    logic             timeout_r;
    logic             wd_run_s;
    logic             wd_hit_s;

    // The watchdog only runs while a response is owed and none arrives.
    assign wd_run_s = (cnt_r != {CNT_WD{1'b0}}) & ~pop_s;
    assign wd_hit_s = wd_run_s & (wd_cnt_r >= (WD_LIMIT - WD_ONE));

    // Stall counter saturates at the limit; the error flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt_r  <= {WD_WD{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            if (!wd_run_s) begin
                wd_cnt_r <= {WD_WD{1'b0}};
            end else if (wd_cnt_r != WD_LIMIT) begin
                wd_cnt_r <= wd_cnt_r + WD_ONE;
            end else begin
                wd_cnt_r <= wd_cnt_r;
            end
            timeout_r <= timeout_r | wd_hit_s;
        end
    end

    assign timeout_err = timeout_r;
`else
    assign timeout_err = 1'b0;
`endif

    assign done_valid      = done_valid_r;
    assign done_ch         = done_ch_r;
    assign done_err        = done_err_r;
    assign outstanding_cnt = cnt_r;

endmodule

// File: tb/tb_dmac_write_resp_tracker.sv
// -----------------------------------------------------------------------------
// Self-checking bench for dmac_write_resp_tracker (default parameters, watchdog
// limit 16). A queue model of the outstanding bursts predicts completions;
// predicted {ch, err, cycle} records are queued and checked by a monitor.
// -----------------------------------------------------------------------------
module tb_dmac_write_resp_tracker;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] issue_ch;
    logic       issue_last;
    logic       m_axi_bvalid;
    logic [1:0] m_axi_bresp;
    logic       m_axi_bready;
    logic       done_valid;
    logic [2:0] done_ch;
    logic       done_err;
    logic [3:0] outstanding_cnt;
    logic       timeout_err;

    always #5 clk = ~clk;

    dmac_write_resp_tracker #(
        .CHANNEL_COUNT     (8),
        .OUTSTANDING_DEPTH (DEPTH),
        .TIMEOUT_CYCLES    (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_ch        (issue_ch),
        .issue_last      (issue_last),
        .m_axi_bvalid    (m_axi_bvalid),
        .m_axi_bresp     (m_axi_bresp),
        .m_axi_bready    (m_axi_bready),
        .done_valid      (done_valid),
        .done_ch         (done_ch),
        .done_err        (done_err),
        .outstanding_cnt (outstanding_cnt),
        .timeout_err     (timeout_err)
    );

    typedef struct { logic [2:0] ch; logic last; } ent_t;
    typedef struct { logic [2:0] ch; logic err; int cyc; } exp_t;

    ent_t       mdl_q[$];
    exp_t       exp_q[$];
    logic [7:0] acc = 8'h00;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_mis = 0;

    // Cycle stamp used to check completion latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: check handshake outputs against the model, update
    // the model for the coming edge, then drive the inputs.
    task automatic step(input logic iv, input logic [2:0] ich, input logic il,
                        input logic bv, input logic [1:0] br);
        logic do_push;
        logic do_pop;
        logic err;
        ent_t h;
        ent_t e;
        exp_t x;
        @(negedge clk);
        chk("outstanding_cnt", 32'(outstanding_cnt), mdl_q.size());
        chk("issue_ready", 32'(issue_ready), 32'(mdl_q.size() < DEPTH));
        chk("m_axi_bready", 32'(m_axi_bready), 32'(mdl_q.size() > 0));
        do_push = iv && (mdl_q.size() < DEPTH);
        do_pop  = bv && (mdl_q.size() > 0);
        err     = (br == 2'b10) || (br == 2'b11);
        if (do_pop) begin
            h = mdl_q.pop_front();
            if (h.last) begin
                x.ch  = h.ch;
                x.err = acc[h.ch] | err;
                x.cyc = cyc + 1;
                exp_q.push_back(x);
                acc[h.ch] = 1'b0;
            end else begin
                acc[h.ch] = acc[h.ch] | err;
            end
        end
        if (do_push) begin
            e.ch   = ich;
            e.last = il;
            mdl_q.push_back(e);
        end
        issue_valid  = iv;
        issue_ch     = ich;
        issue_last   = il;
        m_axi_bvalid = bv;
        m_axi_bresp  = br;
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic do_reset(input int edges);
        @(negedge clk);
        rst          = 1'b0;
        issue_valid  = 1'b0;
        m_axi_bvalid = 1'b0;
        #1;
        chk("rst_issue_ready", 32'(issue_ready), 32'd0);
        chk("rst_bready", 32'(m_axi_bready), 32'd0);
        repeat (edges) @(negedge clk);
        chk("rst_cnt", 32'(outstanding_cnt), 32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_done_ch", 32'(done_ch), 32'd0);
        chk("rst_done_err", 32'(done_err), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        mdl_q.delete();
        acc = 8'h00;
        rst = 1'b1;
    endtask

    // Completion monitor: every pulse must match the oldest prediction, arrive
    // on the predicted cycle, and done_ch/done_err must hold between pulses.
    initial begin
        exp_t       x;
        logic [2:0] hold_ch;
        logic       hold_err;
        bit         seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                seen = 1'b0;
            end else if (done_valid) begin
                chk("done_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    x = exp_q.pop_front();
                    chk("done_ch", 32'(done_ch), 32'(x.ch));
                    chk("done_err", 32'(done_err), 32'(x.err));
                    chk("done_latency", cyc, x.cyc);
                    hold_ch  = x.ch;
                    hold_err = x.err;
                    seen     = 1'b1;
                end
            end else if (seen) begin
                chk("done_ch_hold", 32'(done_ch), 32'(hold_ch));
                chk("done_err_hold", 32'(done_err), 32'(hold_err));
            end
        end
    end

    initial begin
        rst          = 1'b0;
        issue_valid  = 1'b0;
        issue_ch     = 3'd0;
        issue_last   = 1'b0;
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;

        do_reset(2);

        // Three bursts on ch2, all OKAY.
        step(1'b1, 3'd2, 1'b0, 1'b0, 2'b00);
        step(1'b1, 3'd2, 1'b0, 1'b0, 2'b00);
        step(1'b1, 3'd2, 1'b1, 1'b0, 2'b00);
        repeat (3) step(1'b0, 3'd0, 1'b0, 1'b1, 2'b00);
        repeat (2) idle();

        // ch1: SLVERR then OKAY, then a clean ch1 transfer.
        step(1'b1, 3'd1, 1'b0, 1'b0, 2'b00);
        step(1'b1, 3'd1, 1'b1, 1'b0, 2'b00);
        step(1'b0, 3'd0, 1'b0, 1'b1, 2'b10);
        step(1'b0, 3'd0, 1'b0, 1'b1, 2'b00);
        step(1'b1, 3'd1, 1'b0, 1'b0, 2'b00);
        step(1'b1, 3'd1, 1'b1, 1'b0, 2'b00);
        step(1'b0, 3'd0, 1'b0, 1'b1, 2'b01);
        step(1'b0, 3'd0, 1'b0, 1'b1, 2'b00);
        repeat (2) idle();

        // Fill to depth, push rejected during a pop, then accepted.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 3'd3, (i == DEPTH - 1), 1'b0, 2'b00);
        step(1'b1, 3'd1, 1'b1, 1'b1, 2'b00);
        step(1'b1, 3'd6, 1'b1, 1'b0, 2'b00);
        idle();
        for (int i = 0; i < DEPTH; i++) step(1'b0, 3'd0, 1'b0, 1'b1, (i == 2) ? 2'b10 : 2'b01);
        repeat (2) idle();

        // Interleaved single-burst transfers, back-to-back responses.
        step(1'b1, 3'd0, 1'b1, 1'b0, 2'b00);
        step(1'b1, 3'd5, 1'b1, 1'b0, 2'b00);
        step(1'b0, 3'd0, 1'b0, 1'b1, 2'b11);
        step(1'b0, 3'd0, 1'b0, 1'b1, 2'b00);
        repeat (2) idle();
        step(1'b0, 3'd0, 1'b0, 1'b1, 2'b00);
        repeat (2) idle();

        // Interleaved multi-burst transfers with an error only on ch1.
        step(1'b1, 3'd1, 1'b0, 1'b0, 2'b00);
        step(1'b1, 3'd2, 1'b0, 1'b0, 2'b00);
        step(1'b1, 3'd1, 1'b1, 1'b1, 2'b10);
        step(1'b1, 3'd2, 1'b1, 1'b1, 2'b00);
        step(1'b0, 3'd0, 1'b0, 1'b1, 2'b00);
        step(1'b0, 3'd0, 1'b0, 1'b1, 2'b01);
        repeat (2) idle();

        // Random traffic, then drain.
        for (int i = 0; i < 80; i++)
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 3'd0, 1'b0, 1'b1, 2'b00);
        repeat (2) idle();

        // Watchdog with one stalled entry, then reset mid-burst.
        step(1'b1, 3'd7, 1'b1, 1'b0, 2'b00);
        repeat (10) idle();
        chk("timeout_early", 32'(timeout_err), 32'd0);
        repeat (10) idle();
`ifdef DMAC_WR_RESP_TIMEOUT_EN
        chk("timeout_set", 32'(timeout_err), 32'd1);
        repeat (3) idle();
        chk("timeout_sticky", 32'(timeout_err), 32'd1);
`else
        chk("timeout_tied", 32'(timeout_err), 32'd0);
`endif
        do_reset(1);
        repeat (3) idle();

        chk("pending_done", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dmac_write_resp_tracker.md
DMAC_WRITE_RESP_TRACKER -- requirements
Module: dmac_write_resp_tracker

Interface
REQ-001 Parameter CHANNEL_COUNT, default 8: number of DMA channels; CH_WD = max(1, $clog2(CHANNEL_COUNT)).
REQ-002 Parameter OUTSTANDING_DEPTH, default 8: max in-flight write bursts; power of two, >= 2.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit; used only under DMAC_WR_RESP_TIMEOUT_EN.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-006 issue_valid  input  1  AW handshake of one burst completed this cycle.
REQ-007 issue_ready  output  1  tracker can record another burst; issuer SHALL NOT fire AW while low.
REQ-008 issue_ch  input  CH_WD  channel owning the burst.
REQ-009 issue_last  input  1  burst is the final burst of that channel's transfer.
REQ-010 m_axi_bvalid  input  1  AXI write response valid.
REQ-011 m_axi_bresp  input  2  AXI write response code.
REQ-012 m_axi_bready  output  1  AXI write response ready.
REQ-013 done_valid  output  1  one-cycle pulse: a channel's transfer fully acknowledged.
REQ-014 done_ch  output  CH_WD  channel of the completed transfer.
REQ-015 done_err  output  1  any burst of that transfer returned an error.
REQ-016 outstanding_cnt  output  $clog2(OUTSTANDING_DEPTH)+1  bursts awaiting response.
REQ-017 timeout_err  output  1  sticky watchdog error.

Function
REQ-018 Tracker SHALL hold an in-order FIFO of {ch, last} entries, depth OUTSTANDING_DEPTH; push when issue_valid && issue_ready.
REQ-019 issue_ready SHALL be 1 iff outstanding_cnt < OUTSTANDING_DEPTH; no push-when-full even if a pop occurs that cycle.
REQ-020 m_axi_bready SHALL be 1 iff FIFO non-empty (combinational from registered count); B handshake pops the head entry.
REQ-021 Push and pop in the same cycle SHALL leave outstanding_cnt unchanged; pointers wrap modulo OUTSTANDING_DEPTH.
REQ-022 A response is an error iff m_axi_bresp[1] == 1 (SLVERR 2'b10, DECERR 2'b11); OKAY and EXOKAY are success.
REQ-023 Per-channel sticky err_acc[ch] SHALL OR in the error flag on each popped non-last burst of ch.
REQ-024 On pop of a last entry: next cycle done_valid=1, done_ch=head ch, done_err=err_acc[ch] | current error flag; err_acc[ch] cleared in that same update.
REQ-025 done_valid SHALL be high exactly one cycle per last-entry pop (latency 1 cycle after B handshake); back-to-back last pops give back-to-back pulses.
REQ-026 done_ch/done_err SHALL hold their last values when done_valid is 0.
REQ-027 Interleaved channels SHALL keep independent err_acc; an error on channel A SHALL NOT affect channel B's done_err.
REQ-028 bvalid with empty FIFO SHALL be ignored (bready=0); no state change.

Reset
REQ-029 While rst=0 at a clock edge: FIFO empty, outstanding_cnt=0, all err_acc=0, done_valid=0, done_ch=0, done_err=0, timeout_err=0, watchdog counter=0.
REQ-030 During reset, issue_ready=0 and m_axi_bready=0; reset mid-operation discards all in-flight entries without emitting done pulses.

Configuration
REQ-031 Macro DMAC_WR_RESP_TIMEOUT_EN defined: counter increments each cycle FIFO is non-empty without a B handshake, clears on B handshake or empty FIFO; reaching TIMEOUT_CYCLES sets timeout_err=1, sticky until reset.
REQ-032 Macro undefined: no watchdog logic; timeout_err tied to 0; port list unchanged.

Verification
REQ-033 Push 3 bursts ch=2 (last on 3rd), 3 OKAY responses -> single done_valid one cycle after 3rd B handshake, done_ch=2, done_err=0, outstanding_cnt 3->0.
REQ-034 ch=1 two bursts, responses SLVERR then OKAY -> done_ch=1, done_err=1; next ch=1 transfer all OKAY -> done_err=0.
REQ-035 Fill 8 entries (depth 8) -> issue_ready=0; assert issue_valid+B handshake same cycle -> push rejected, count 7; next cycle push accepted, count 8.
REQ-036 Interleave ch0 (DECERR) and ch5 (OKAY) single-burst last transfers -> done pulses in issue order, ch0 err=1, ch5 err=0; bvalid while empty -> bready=0, no pulse.
REQ-037 With DMAC_WR_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=16, one entry, bvalid held 0 -> timeout_err=1 after 16 cycles, stays 1; rst=0 for one edge mid-burst -> all outputs 0, no done pulse.
